// File: rtl/fir_hls_div_pkg.sv
// fir_hls_div_pkg: shared widths, FSM states and saturation bounds for the sequential signed divider
package fir_hls_div_pkg;
  localparam int DIVIDEND_WIDTH = 30;
  localparam int DIVISOR_WIDTH = 14;
  localparam int QUOTIENT_WIDTH = 16;
  localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH);
  localparam logic signed [QUOTIENT_WIDTH-1:0] QMAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
  localparam logic signed [QUOTIENT_WIDTH-1:0] QMIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIN, DONE} state_t;
endpackage

// File: rtl/fir_hls_udiv_step.sv
// fir_hls_udiv_step: one combinational radix-2 restoring step (shift in a bit, trial subtract, select)
module fir_hls_udiv_step
  import fir_hls_div_pkg::*;
(
  input  logic [DIVISOR_WIDTH:0]   prem,
  input  logic                     bit_in,
  input  logic [DIVISOR_WIDTH-1:0] dmag,
  output logic [DIVISOR_WIDTH:0]   prem_n,
  output logic                     qbit
);
  logic [DIVISOR_WIDTH+1:0] sh;
  assign sh = {prem, bit_in};
  assign qbit = sh >= (DIVISOR_WIDTH+2)'(dmag);
  assign prem_n = qbit ? (DIVISOR_WIDTH+1)'(sh - (DIVISOR_WIDTH+2)'(dmag)) : (DIVISOR_WIDTH+1)'(sh);
endmodule

// File: rtl/fir_hls_sdiv_30s_14s_16_seq.sv
// fir_hls_sdiv_30s_14s_16_seq: sequential signed restoring divider with saturated 16-bit quotient
module fir_hls_sdiv_30s_14s_16_seq
  import fir_hls_div_pkg::*;
(
  input  logic                              ap_clk,
  input  logic                              ap_rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0]  dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]   divisor,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [QUOTIENT_WIDTH-1:0]  quotient,
  output logic signed [DIVISOR_WIDTH-1:0]   remainder,
  output logic                              ovf,
  output logic                              div0
);
  state_t state, state_n;
  logic signed [DIVIDEND_WIDTH-1:0] dvd;
  logic signed [DIVISOR_WIDTH-1:0] dvs;
  logic [DIVIDEND_WIDTH-1:0] acc;
  logic [DIVISOR_WIDTH-1:0] dmag;
  logic [DIVISOR_WIDTH:0] prem, prem_n;
  logic qbit;
  logic [CNT_WIDTH-1:0] cnt;
  logic neg_q, neg_r, zero;
  logic signed [DIVIDEND_WIDTH:0] q_s;
  logic ovf_hi, ovf_lo;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // acc shifts dividend magnitude bits out of the top while quotient bits enter at the bottom
  fir_hls_udiv_step u_step (
    .prem   (prem),
    .bit_in (acc[DIVIDEND_WIDTH-1]),
    .dmag   (dmag),
    .prem_n (prem_n),
    .qbit   (qbit)
  );
  assign q_s = neg_q ? -$signed({1'b0, acc}) : $signed({1'b0, acc});
  assign ovf_hi = !q_s[DIVIDEND_WIDTH] && |q_s[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH-1];
  assign ovf_lo = q_s[DIVIDEND_WIDTH] && !(&q_s[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH-1]);
  // state register
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) state <= IDLE;
    else state <= state_n;
  // next-state logic: fixed-length walk through PREP, 30 CALC steps and FIN
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? PREP : IDLE;
      PREP: state_n = CALC;
      CALC: state_n = cnt == '0 ? FIN : CALC;
      FIN: state_n = DONE;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // datapath: operand capture, magnitudes, restoring iterations, sign fix-up and saturation
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      dvd <= '0;
      dvs <= '0;
      acc <= '0;
      dmag <= '0;
      prem <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      zero <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      ovf <= 1'b0;
      div0 <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          dvd <= dividend;
          dvs <= divisor;
          ovf <= 1'b0;
          div0 <= 1'b0;
        end
        PREP: begin
          acc <= dvd[DIVIDEND_WIDTH-1] ? -dvd : dvd;
          dmag <= dvs[DIVISOR_WIDTH-1] ? -dvs : dvs;
          neg_q <= dvd[DIVIDEND_WIDTH-1] ^ dvs[DIVISOR_WIDTH-1];
          neg_r <= dvd[DIVIDEND_WIDTH-1];
          zero <= dvs == '0;
          prem <= '0;
          cnt <= CNT_WIDTH'(DIVIDEND_WIDTH-1);
        end
        CALC: begin
          prem <= prem_n;
          acc <= {acc[DIVIDEND_WIDTH-2:0], qbit};
          cnt <= cnt - 1'b1;
        end
        FIN: begin
          quotient <= zero ? (neg_r ? QMIN : QMAX) : ovf_hi ? QMAX : ovf_lo ? QMIN : q_s[QUOTIENT_WIDTH-1:0];
          remainder <= zero ? '0 : DIVISOR_WIDTH'(neg_r ? -prem : prem);
          ovf <= !zero && (ovf_hi || ovf_lo);
          div0 <= zero;
        end
        default: ;
      endcase
endmodule
